// File: rtl/pll_rst_seq_if.sv
// Signal bundle between the PLL reset sequencer and the PLL wrapper / reset consumers.
interface pll_rst_seq_if;
  logic       pll_lock;
  logic       sw_rst_req;
  logic       pll_reset;
  logic       periph_rst;
  logic       cpu_rst;
  logic       ready;
  logic [7:0] relock_cnt;

  modport master (
    output pll_lock, sw_rst_req,
    input  pll_reset, periph_rst, cpu_rst, ready, relock_cnt
  );

  modport slave (
    input  pll_lock, sw_rst_req,
    output pll_reset, periph_rst, cpu_rst, ready, relock_cnt
  );
endinterface

// File: rtl/pll_rst_seq.sv
// Reset sequencer behind the PLL wrapper: pulses the PLL reset, qualifies lock,
// then releases peripheral and CPU resets in a fixed order.
//   state    | meaning
//   S_PLLRST | PLL held in reset for PLL_RST_CYCLES
//   S_WAIT   | waiting for synchronized lock, bounded by LOCK_TIMEOUT
//   S_STABLE | counting consecutive lock-high cycles
//   S_PERIPH | peripherals released, CPU held for STAGE_GAP
//   S_RUN    | all resets released
module pll_rst_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_STABLE    = 1024,
  parameter int STAGE_GAP      = 16,
  parameter int SYNC_STAGES    = 2
) (
  input logic          clk,
  input logic          reset,
  pll_rst_seq_if.slave bus
);

  localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD = (LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP;
  localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_C) + 1;

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAIT,
    S_STABLE,
    S_PERIPH,
    S_RUN
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pll_reset_q;
  logic                   periph_rst_q;
  logic                   cpu_rst_q;
  logic                   ready_q;
  logic [7:0]             relock_q;
  logic [7:0]             relock_d;
  logic                   lock_s;

  assign lock_s   = sync_q[SYNC_STAGES-1];
  assign relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_PLLRST;
      cnt_q        <= '0;
      sync_q       <= '0;
      pll_reset_q  <= 1'b1;
      periph_rst_q <= 1'b1;
      cpu_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
      relock_q     <= 8'd0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
      case (state_q)
        S_PLLRST: begin
          if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
            state_q     <= S_WAIT;
            cnt_q       <= '0;
            pll_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (lock_s) begin
            state_q <= S_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            state_q     <= S_PLLRST;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            relock_q    <= relock_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STABLE: begin
          // Chatter before release only restarts the lock wait; it is not a relock.
          if (!lock_s) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
            state_q      <= S_PERIPH;
            cnt_q        <= '0;
            periph_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PERIPH, S_RUN: begin
          if (!lock_s) begin
            state_q      <= S_PLLRST;
            cnt_q        <= '0;
            pll_reset_q  <= 1'b1;
            periph_rst_q <= 1'b1;
            cpu_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            relock_q     <= relock_d;
          end else if (bus.sw_rst_req) begin
            state_q      <= S_STABLE;
            cnt_q        <= '0;
            periph_rst_q <= 1'b1;
            cpu_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
          end else if (state_q == S_PERIPH) begin
            if (cnt_q == CW'(STAGE_GAP - 1)) begin
              state_q   <= S_RUN;
              cnt_q     <= '0;
              cpu_rst_q <= 1'b0;
              ready_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q      <= S_PLLRST;
          cnt_q        <= '0;
          pll_reset_q  <= 1'b1;
          periph_rst_q <= 1'b1;
          cpu_rst_q    <= 1'b1;
          ready_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_reset  = pll_reset_q;
  assign bus.periph_rst = periph_rst_q;
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.ready      = ready_q;
  assign bus.relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq: a timeline model (PLL reset age, lock run length,
// time since release) is compared every cycle, plus hand-computed latency checks.
module tb_pll_rst_seq;

  localparam int PRC  = 4;
  localparam int TO   = 20;
  localparam int LS   = 8;
  localparam int SG   = 3;
  localparam int SYNC = 2;

  logic clk;
  logic reset;
  pll_rst_seq_if bus();

  pll_rst_seq #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (TO),
    .LOCK_STABLE   (LS),
    .STAGE_GAP     (SG),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: age since PLL reset began, lock-wait length, consecutive lock-high
  // count, cycles since peripheral release (-1 = not released), relock count.
  int m_age, m_wait, m_hi, m_rel, m_relock;
  bit m_lq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_age = 0; m_wait = 0; m_hi = 0; m_rel = -1; m_relock = 0;
    m_lq.delete();
    for (int i = 0; i < SYNC; i++) m_lq.push_back(1'b0);
  endtask

  task automatic kick();
    m_age = 0; m_wait = 0; m_hi = 0; m_rel = -1;
    if (m_relock < 255) m_relock++;
  endtask

  task automatic model_step();
    bit l;
    l = m_lq.pop_front();
    m_lq.push_back(bus.pll_lock);
    if (m_age < PRC) begin
      m_age++;
      m_wait = 0;
    end else if (m_rel >= 0) begin
      if (!l) kick();
      else if (bus.sw_rst_req) begin
        m_rel = -1;
        m_hi  = 1;
      end else if (m_rel < SG) m_rel++;
    end else if (l) begin
      m_hi++;
      if (m_hi == LS + 1) m_rel = 0;
    end else if (m_hi > 0) begin
      m_hi   = 0;
      m_wait = 0;
    end else begin
      m_wait++;
      if (m_wait == TO) kick();
    end
  endtask

  task automatic check_all();
    chk("pll_reset",  int'(bus.pll_reset),  int'(m_age < PRC));
    chk("periph_rst", int'(bus.periph_rst), int'(m_rel < 0));
    chk("cpu_rst",    int'(bus.cpu_rst),    int'(m_rel < SG));
    chk("ready",      int'(bus.ready),      int'(m_rel >= SG));
    chk("relock_cnt", int'(bus.relock_cnt), m_relock);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic get_out(input int which);
    case (which)
      0:       return bus.pll_reset;
      1:       return bus.periph_rst;
      2:       return bus.cpu_rst;
      default: return bus.ready;
    endcase
  endfunction

  task automatic run_until(input int which, input logic val, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (get_out(which) == val) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout: output %0d never reached %0d within %0d cycles", which, val, maxc);
    end
  endtask

  task automatic do_reset();
    bus.pll_lock   = 1'b0;
    bus.sw_rst_req = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst_pll_reset",  int'(bus.pll_reset), 1);
    chk("rst_periph_rst", int'(bus.periph_rst), 1);
    chk("rst_relock_cnt", int'(bus.relock_cnt), 0);
    reset = 1'b0;
  endtask

  int n, cnt;

  initial begin
    reset = 1'b1;
    bus.pll_lock   = 1'b0;
    bus.sw_rst_req = 1'b0;
    model_reset();

    // Power-up: PLL reset width, lock-to-release latency, stage gap.
    do_reset();
    run_until(0, 1'b0, 10, n);
    chk("pwrup_pll_reset_width", n, 4);
    repeat (10 - n) tick();
    bus.pll_lock = 1'b1;
    run_until(1, 1'b0, 40, n);
    chk("pwrup_periph_latency", n, 11);
    run_until(2, 1'b0, 20, n);
    chk("pwrup_cpu_gap", n, 3);
    chk("pwrup_ready", int'(bus.ready), 1);
    chk("pwrup_relock", int'(bus.relock_cnt), 0);

    // Lock loss in S_RUN, then recovery.
    bus.pll_lock = 1'b0;
    run_until(0, 1'b1, 10, n);
    chk("loss_latency", n, 3);
    chk("loss_periph_rst", int'(bus.periph_rst), 1);
    chk("loss_ready", int'(bus.ready), 0);
    chk("loss_relock", int'(bus.relock_cnt), 1);
    bus.pll_lock = 1'b1;
    run_until(3, 1'b1, 60, n);
    chk("relock_to_ready", n, 16);
    chk("relock_unchanged", int'(bus.relock_cnt), 1);

    // Soft reset in S_RUN.
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    chk("sw_periph_rst", int'(bus.periph_rst), 1);
    chk("sw_cpu_rst", int'(bus.cpu_rst), 1);
    chk("sw_pll_reset", int'(bus.pll_reset), 0);
    run_until(1, 1'b0, 20, n);
    chk("sw_periph_latency", n, 8);
    run_until(2, 1'b0, 20, n);
    chk("sw_cpu_gap", n, 3);

    // Asynchronous reset while in S_PERIPH, between clock edges.
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    run_until(1, 1'b0, 20, n);
    chk("sw2_periph_latency", n, 8);
    #2;
    reset = 1'b1;
    #1;
    chk("async_pll_reset", int'(bus.pll_reset), 1);
    chk("async_periph_rst", int'(bus.periph_rst), 1);
    chk("async_cpu_rst", int'(bus.cpu_rst), 1);
    chk("async_ready", int'(bus.ready), 0);
    chk("async_relock", int'(bus.relock_cnt), 0);
    model_reset();
    bus.pll_lock = 1'b0;
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // Soft reset request in S_WAIT is ignored.
    repeat (6) tick();
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    chk("sw_wait_pll_reset", int'(bus.pll_reset), 0);
    chk("sw_wait_periph_rst", int'(bus.periph_rst), 1);
    bus.pll_lock = 1'b1;
    run_until(1, 1'b0, 40, n);
    chk("sw_wait_periph_latency", n, 11);

    // Lock chatter before release.
    do_reset();
    repeat (10) tick();
    bus.pll_lock = 1'b1;
    repeat (5) tick();
    bus.pll_lock = 1'b0;
    repeat (2) tick();
    bus.pll_lock = 1'b1;
    run_until(1, 1'b0, 40, n);
    chk("chatter_periph_latency", n, 11);
    chk("chatter_relock", int'(bus.relock_cnt), 0);

    // Lock never arrives: 4-cycle PLL pulses every 24 cycles.
    do_reset();
    cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i > 4 && bus.pll_reset) cnt++;
    end
    chk("nolock_pulse_cycles", cnt, 16);
    chk("nolock_relock", int'(bus.relock_cnt), 4);
    chk("nolock_periph_rst", int'(bus.periph_rst), 1);

    // Saturation after 300 timeouts.
    do_reset();
    repeat (300 * (PRC + TO) + 10) tick();
    chk("sat_relock", int'(bus.relock_cnt), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
